// File: rtl/timer_pkg.sv
// Shared definitions for the memory-mapped down-counting timer: FSM states,
// register offsets, CTRL bit positions and MODE codes.
package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_e;

  localparam logic [1:0] OFF_CTRL   = 2'b00;
  localparam logic [1:0] OFF_PRESET = 2'b01;
  localparam logic [1:0] OFF_COUNT  = 2'b10;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_IM      = 3;
  localparam int CTRL_PSC_LO  = 4;
  localparam int CTRL_PSC_HI  = 7;

  localparam logic [1:0] MODE_AUTO = 2'b01;

  function automatic logic is_auto(input logic [7:0] ctrl);
    return ctrl[CTRL_MODE_HI:CTRL_MODE_LO] == MODE_AUTO;
  endfunction

endpackage

// File: rtl/timer_prescaler.sv
// 4-bit divider producing a one-cycle tick every PSC+1 cycles while not held clear.
// Only built when TIMER_PRESCALE_EN is defined.
`ifdef TIMER_PRESCALE_EN
module timer_prescaler (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_clr,
  input  logic [3:0] i_psc,
  output logic       o_tick
);

  logic [3:0] r_div;

  // >= keeps the divider from running away if PSC is lowered mid-count
  assign o_tick = !i_clr && (r_div >= i_psc);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div <= '0;
    end else if (i_clr || o_tick) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + 4'd1;
    end
  end

endmodule
`endif

// File: rtl/timer_unit.sv
// Memory-mapped down-counting timer with CTRL/PRESET/COUNT registers and level IRQ.
// Optional CTRL[7:4] prescaler enabled by defining TIMER_PRESCALE_EN.
module timer_unit
  import timer_pkg::*;
#(
  parameter int          CNT_W      = 32,
  parameter logic [31:0] PRESET_RST = 32'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:2] Addr,
  input  logic        WE,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  output logic        IRQ
);

`ifdef TIMER_PRESCALE_EN
  localparam logic [7:0] CTRL_MASK = 8'hFF;
`else
  localparam logic [7:0] CTRL_MASK = 8'h0F;
`endif

  state_e           r_state, w_state_nxt;
  logic [7:0]       r_ctrl;
  logic [CNT_W-1:0] r_preset;
  logic [CNT_W-1:0] r_count, w_count_nxt;
  logic             r_irq_flag, w_irq_flag_nxt;
  logic             w_en_clr;
  logic             w_wr_ctrl, w_wr_preset;
  logic             w_auto, w_tick;
  logic             w_unused;

  assign w_wr_ctrl   = WE && (Addr[3:2] == OFF_CTRL);
  assign w_wr_preset = WE && (Addr[3:2] == OFF_PRESET);
  assign w_auto      = is_auto(r_ctrl);
  assign w_unused    = ^{Addr[31:4], Din[31:8]};

`ifdef TIMER_PRESCALE_EN
  timer_prescaler u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .i_clr  (r_state != ST_CNT),
    .i_psc  (r_ctrl[CTRL_PSC_HI:CTRL_PSC_LO]),
    .o_tick (w_tick)
  );
`else
  assign w_tick = 1'b1;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_count_nxt    = r_count;
    w_irq_flag_nxt = r_irq_flag;
    w_en_clr       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_ctrl[CTRL_EN]) w_state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        w_count_nxt = r_preset;
        w_state_nxt = ST_CNT;
      end
      ST_CNT: begin
        if (!r_ctrl[CTRL_EN]) begin
          w_state_nxt = ST_IDLE;
        end else if (w_tick) begin
          if (r_count > CNT_W'(1)) begin
            w_count_nxt = r_count - CNT_W'(1);
          end else begin
            w_count_nxt    = '0;
            w_irq_flag_nxt = 1'b1;
            w_state_nxt    = ST_INT;
          end
        end
      end
      ST_INT: begin
        if (w_auto) begin
          w_irq_flag_nxt = 1'b0;
          w_state_nxt    = ST_LOAD;
        end else begin
          w_en_clr    = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    // Software acknowledge of a one-shot interrupt wins over the FSM setting it
    if ((w_wr_ctrl || w_wr_preset) && !w_auto) w_irq_flag_nxt = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ctrl     <= '0;
      r_preset   <= PRESET_RST[CNT_W-1:0];
      r_count    <= '0;
      r_irq_flag <= 1'b0;
    end else begin
      r_count    <= w_count_nxt;
      r_irq_flag <= w_irq_flag_nxt;
      if (w_wr_ctrl) begin
        r_ctrl <= Din[7:0] & CTRL_MASK;
      end else if (w_en_clr) begin
        r_ctrl[CTRL_EN] <= 1'b0;
      end
      if (w_wr_preset) r_preset <= Din[CNT_W-1:0];
    end
  end

  always_comb begin
    Dout = '0;
    case (Addr[3:2])
      OFF_CTRL:   Dout = {24'd0, r_ctrl};
      OFF_PRESET: Dout = 32'(r_preset);
      OFF_COUNT:  Dout = 32'(r_count);
      default:    Dout = '0;
    endcase
  end

  assign IRQ = r_ctrl[CTRL_IM] & r_irq_flag;

endmodule
